// File: rtl/mux_sel_rr_arbiter_if.sv
// Handshake bundle between the ALU16 requesters and the shared result-mux arbiter.
interface mux_sel_rr_arbiter_if;
    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             timeout;

    modport master (output req, last, input gnt, sel, busy, timeout);
    modport slave  (input req, last, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter for an 8:1 result mux; grants are held across multi-beat bursts.
// Optional grant-length limit enabled by defining ARB_TIMEOUT_EN.
module mux_sel_rr_arbiter #(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CW        = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_sel_rr_arbiter_if.slave   bus
);
    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {IDLE, GRANT} state_e;

    if (2**CW <= MAX_BEATS) begin : g_cw_check
        $error("CW too narrow for MAX_BEATS");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [SEL_W:0]   pick;
    logic             done;
    logic             expire;
`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // First set bit of r scanning base, base+1, ... (mod 8); MSB flags a hit.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] base);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = base;
        for (int k = 0; k < N_REQ; k++) begin
            cand = base + SEL_W'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        done    = 1'b0;
        expire  = 1'b0;
        pick    = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
                if (pick[SEL_W]) begin
                    gnt_d   = N_REQ'(1) << pick[SEL_W-1:0];
                    sel_d   = pick[SEL_W-1:0];
                    busy_d  = 1'b1;
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                // Only the owner's own req/last bits can end its burst.
                done = !bus.req[sel_q] || bus.last[sel_q];
`ifdef ARB_TIMEOUT_EN
                expire    = !done && (cnt_q == CW'(MAX_BEATS - 1));
                timeout_d = expire;
                cnt_d     = cnt_q + CW'(1);
`endif
                pick = rr_pick(bus.req & ~gnt_q, sel_q + SEL_W'(1));
                if (done || expire) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pick[SEL_W]) begin
                        gnt_d = N_REQ'(1) << pick[SEL_W-1:0];
                        sel_d = pick[SEL_W-1:0];
`ifdef ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: directed scenarios plus random traffic vs. a model.
module tb_mux_sel_rr_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_MAX = 4;
`else
    localparam int unsigned TB_MAX = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mux_sel_rr_arbiter_if bus ();
    mux_sel_rr_arbiter #(.MAX_BEATS(TB_MAX), .CW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference model: owner index (-1 = idle), rotation pointer, beats held, last select.
    int m_owner, m_ptr, m_sel, m_beats;
    bit m_to;

    function automatic int search(input int from, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        logic [7:0] e;
        e = '0;
        if (m_owner >= 0) e[m_owner] = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] l);
        int  g, w;
        bit  ended, exp_limit;
        logic [7:0] m;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = search(m_ptr, r);
            if (w >= 0) begin m_owner = w; m_sel = w; m_beats = 0; end
        end else begin
            g = m_owner;
            ended = !r[g] || l[g];
            exp_limit = 1'b0;
`ifdef ARB_TIMEOUT_EN
            exp_limit = !ended && (m_beats == TB_MAX - 1);
`endif
            if (ended || exp_limit) begin
                m_ptr = (g + 1) % 8;
                m = r;
                m[g] = 1'b0;
                w = search(m_ptr, m);
                if (w >= 0) begin m_owner = w; m_sel = w; m_beats = 0; end
                else m_owner = -1;
                m_to = exp_limit;
            end else begin
                m_beats++;
            end
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] l);
        bus.req  = r;
        bus.last = l;
        @(posedge clk);
        model_step(r, l);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0; bus.last = '0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 8'hFF; bus.last = 8'h00;
        #3;
        tests++;
        if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state gnt=%h sel=%0d busy=%b to=%b expected all zero",
                     bus.gnt, bus.sel, bus.busy, bus.timeout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(8'h04, 8'h04);
        tests++;
        if (bus.gnt !== 8'h04 || bus.sel !== 3'd2 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL single_grant gnt=%h sel=%0d expected 04/2", bus.gnt, bus.sel);
        end
        drive(8'h04, 8'h04);
        tests++;
        if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.sel !== 3'd2) begin
            fails++; $display("FAIL single_release gnt=%h busy=%b sel=%0d expected 00/0/2",
                              bus.gnt, bus.busy, bus.sel);
        end
        drive(8'h0C, 8'h0C);
        tests++;
        if (bus.gnt !== 8'h08) begin
            fails++; $display("FAIL single_ptr3 gnt=%h expected 08", bus.gnt);
        end
        drive(8'h00, 8'h00);
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(8'hFF, 8'hFF);
            tests++;
            if (bus.sel !== 3'(k % 8) || bus.busy !== 1'b1 || bus.gnt !== (8'h01 << (k % 8))) begin
                fails++; $display("FAIL rotation step %0d sel=%0d busy=%b expected sel=%0d busy=1",
                                  k, bus.sel, bus.busy, k % 8);
            end
        end
        drive(8'h00, 8'h00);
        drive(8'h00, 8'h00);
    endtask

    task automatic test_burst();
        do_reset();
        drive(8'h20, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (bus.gnt !== 8'h20) begin
                fails++; $display("FAIL burst_hold cycle %0d gnt=%h expected 20", k, bus.gnt);
            end
            drive(8'h22, (k == 3) ? 8'h20 : 8'h00);
        end
        tests++;
        if (bus.gnt !== 8'h02 || bus.sel !== 3'd1 || bus.timeout !== 1'b0) begin
            fails++; $display("FAIL burst_switch gnt=%h sel=%0d to=%b expected 02/1/0",
                              bus.gnt, bus.sel, bus.timeout);
        end
        drive(8'h02, 8'h02);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(8'h08, 8'h00);
        drive(8'h08, 8'h00);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_mid gnt=%h sel=%0d busy=%b expected 00/0/0",
                              bus.gnt, bus.sel, bus.busy);
        end
        model_reset();
        bus.req = 8'hFF; bus.last = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(8'hFF, 8'hFF);
        tests++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
            fails++; $display("FAIL reset_mid_restart gnt=%h sel=%0d expected 01/0", bus.gnt, bus.sel);
        end
        drive(8'h00, 8'h00);
        drive(8'h00, 8'h00);
    endtask

    task automatic test_abandon();
        do_reset();
        drive(8'h80, 8'h00);
        drive(8'h00, 8'h00);
        tests++;
        if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.sel !== 3'd7) begin
            fails++; $display("FAIL abandon gnt=%h busy=%b sel=%0d expected 00/0/7",
                              bus.gnt, bus.busy, bus.sel);
        end
        drive(8'h81, 8'h81);
        tests++;
        if (bus.gnt !== 8'h01) begin
            fails++; $display("FAIL abandon_wrap gnt=%h expected 01", bus.gnt);
        end
        drive(8'h00, 8'h00);
    endtask

    task automatic test_timeout();
        do_reset();
        drive(8'h40, 8'h00);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (bus.gnt !== 8'h40 || bus.timeout !== 1'b0) begin
                fails++; $display("FAIL timeout_hold cycle %0d gnt=%h to=%b expected 40/0",
                                  k, bus.gnt, bus.timeout);
            end
            drive(8'h41, 8'h00);
        end
        tests++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_revoke gnt=%h sel=%0d to=%b expected 01/0/1",
                              bus.gnt, bus.sel, bus.timeout);
        end
        drive(8'h01, 8'h01);
        tests++;
        if (bus.timeout !== 1'b0 || bus.gnt !== 8'h00) begin
            fails++; $display("FAIL timeout_pulse to=%b gnt=%h expected 0/00", bus.timeout, bus.gnt);
        end
`else
        for (int k = 0; k < 20; k++) begin
            drive(8'h41, 8'h00);
            tests++;
            if (bus.gnt !== 8'h40 || bus.timeout !== 1'b0) begin
                fails++; $display("FAIL no_timeout cycle %0d gnt=%h to=%b expected 40/0",
                                  k, bus.gnt, bus.timeout);
            end
        end
        drive(8'h00, 8'h00);
`endif
        drive(8'h00, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] r, l;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            r = 8'($urandom) | 8'($urandom);
            l = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if (($urandom % 16) == 0) r = '0;
            drive(r, l);
            tests++;
            if (bus.gnt !== exp_gnt() || bus.sel !== 3'(m_sel) ||
                bus.busy !== (m_owner >= 0) || bus.timeout !== m_to) begin
                fails++;
                $display("FAIL random n=%0d gnt=%h sel=%0d busy=%b to=%b expected %h/%0d/%b/%b",
                         n, bus.gnt, bus.sel, bus.busy, bus.timeout,
                         exp_gnt(), m_sel, (m_owner >= 0), m_to);
            end
        end
    endtask

    initial begin
        rst = 1'b0; bus.req = '0; bus.last = '0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_burst();
        test_reset_mid();
        test_abandon();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
